// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: feeds operands LSB-first through one fulladder cell,
// recirculating carry through a flop, and pulses done when {cout,sum} is valid.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fa_s, fa_c;

    fulladder u_fa (
        .x (a_q[0]),
        .y (b_q[0]),
        .z (carry_q),
        .S (fa_s),
        .C (fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ps_d    = ps_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts start exactly like IDLE so operations can run back-to-back
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    ps_d    = '0;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                ps_d    = {fa_s, ps_q[WIDTH-1:1]};
                carry_d = fa_c;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = {fa_s, ps_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ps_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ps_q    <= ps_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
endmodule

// Single-bit full adder cell used as the serial adder's datapath.
module fulladder (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic S,
    output logic C
);
    assign S = x ^ y ^ z;
    assign C = (x & y) | (x & z) | (y & z);
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder (WIDTH=8 and WIDTH=4) against a plain-arithmetic model.
module tb_serial_adder;
    logic       clk, rst;
    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_sum8;
    logic       exp_cout8;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one WIDTH=8 addition; returns sampled in the DONE cycle.
    task automatic do_op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          input bit chained, input bit poke);
        logic [8:0] r;
        r = {1'b0, ia} + {1'b0, ib} + {8'b0, ic};
        if (!chained) @(negedge clk);
        start8 = 1'b1; a8 = ia; b8 = ib; cin8 = ic;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        chk("acc_busy", 64'(busy8), 64'(1'b1));
        chk("acc_done", 64'(done8), 64'(1'b0));
        chk("acc_hold", 64'({cout8, sum8}), 64'({exp_cout8, exp_sum8}));
        for (int k = 1; k <= 8; k++) begin
            if (poke && k == 3) begin start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
            if (poke && k == 5) start8 = 1'b0;
            @(posedge clk); #1;
            if (k < 8) begin
                chk("shift_busy", 64'(busy8), 64'(1'b1));
                chk("shift_done", 64'(done8), 64'(1'b0));
                chk("shift_hold", 64'({cout8, sum8}), 64'({exp_cout8, exp_sum8}));
            end else begin
                exp_sum8  = r[7:0];
                exp_cout8 = r[8];
                chk("fin_done", 64'(done8), 64'(1'b1));
                chk("fin_busy", 64'(busy8), 64'(1'b0));
                chk("fin_res", 64'({cout8, sum8}), 64'(r));
            end
        end
    endtask

    task automatic idle_chk8(input string tag);
        @(posedge clk); #1;
        chk({tag, "_done"}, 64'(done8), 64'(1'b0));
        chk({tag, "_busy"}, 64'(busy8), 64'(1'b0));
        chk({tag, "_res"}, 64'({cout8, sum8}), 64'({exp_cout8, exp_sum8}));
    endtask

    task automatic do_op4(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
        logic [4:0] r;
        r = {1'b0, ia} + {1'b0, ib} + {4'b0, ic};
        @(negedge clk);
        start4 = 1'b1; a4 = ia; b4 = ib; cin4 = ic;
        @(posedge clk); #1;
        start4 = 1'b0;
        chk("w4_acc_done", 64'(done4), 64'(1'b0));
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k < 4) chk("w4_shift_done", 64'(done4), 64'(1'b0));
            else begin
                chk("w4_fin_done", 64'(done4), 64'(1'b1));
                chk("w4_fin_res", 64'({cout4, sum4}), 64'(r));
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        exp_sum8 = '0; exp_cout8 = 1'b0;
        #12;
        chk("rst_busy8", 64'(busy8), 64'(1'b0));
        chk("rst_done8", 64'(done8), 64'(1'b0));
        chk("rst_res8", 64'({cout8, sum8}), 64'(9'h0));
        chk("rst_res4", 64'({busy4, done4, cout4, sum4}), 64'(7'h0));
        @(negedge clk); rst = 1'b0;

        do_op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        idle_chk8("hold1");
        idle_chk8("hold2");
        do_op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        do_op8(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        do_op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        idle_chk8("no_2nd_done");
        do_op8(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
        do_op8(8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
        idle_chk8("after_chain");

        // abort partway through the operand bits
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy8), 64'(1'b0));
        chk("abort_done", 64'(done8), 64'(1'b0));
        chk("abort_res", 64'({cout8, sum8}), 64'(9'h0));
        exp_sum8 = '0; exp_cout8 = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10; i++) idle_chk8("post_abort");
        do_op8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            bit ch;
            ch = ($urandom_range(0, 1) == 1);
            if (!ch) repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op8(8'($urandom), 8'($urandom), 1'($urandom), ch, 1'b0);
        end

        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    do_op4(4'(ia), 4'(ib), 1'(ic));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
